// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core
// load/store port (port 0) and the loader/debug port (port 1). One access
// at a time: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
// Optional build macro: DMEM_ARB_RR_EN selects round-robin tie breaking;
// without it port 1 always wins simultaneous requests.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        core_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        owner;
  logic        we_q;

  logic        win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic last;

  // Tie goes to the port that was not served last; a lone request always wins.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last;
  end

  // Last-served pointer, refreshed once the access is issued.
  always_ff @(posedge clk) begin
    if (rst) last <= 1'b1;
    else if (state == ACCESS) last <= owner;
  end
`else
  // Fixed priority: port 1 wins whenever it requests.
  always_comb begin
    win = req1;
  end
`endif

  // Request fields of the winning port.
  always_comb begin
    sel_we    = win ? we1    : we0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
  end

  // Core must hold while its request is outstanding and not completing now.
  always_comb begin
    core_stall = req0 & ~rvalid0;
  end

  // Sequencer: all handshake and memory-side outputs are registered pulses,
  // loaded on the edge that enters the state in which they are visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      we_q      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= win;
            we_q      <= sel_we;
            gnt0      <= ~win;
            gnt1      <= win;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr & 32'hFFFF_FFFC;
            mem_wdata <= sel_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          cnt   <= 4'(MEM_LAT);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            cnt     <= '0;
            rvalid0 <= ~owner;
            rvalid1 <= owner;
            if (owner) rdata1 <= we_q ? 32'h0 : mem_rdata;
            else       rdata0 <= we_q ? 32'h0 : mem_rdata;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (MEM_LAT 1 and 4), each
// with a small latency-accurate memory model. Stimulus pushes expected grants
// and responses; per-instance monitors pop and compare when the DUT presents
// them. DMEM_ARB_RR_EN, when defined, changes the expected tie order.
module tb_dmem_arbiter;

  typedef struct {
    bit          port;
    int          cyc;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } rexp_t;

  logic clk;
  logic [1:0] rst_v, req0_v, req1_v, we0_v, we1_v;
  logic [1:0] gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, core_stall_v, mem_en_v, mem_we_v;
  logic [1:0][31:0] addr0_v, addr1_v, wdata0_v, wdata1_v;
  logic [1:0][31:0] rdata0_v, rdata1_v, mem_addr_v, mem_wdata_v, mem_rdata_v;

  gexp_t gnt_q [2][$];
  rexp_t rsp_q [2][$];
  bit    last_served [2];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned LAT = (g == 0) ? 1 : 4;
    logic [31:0] mem  [0:15];
    logic [31:0] pipe [0:3];

    dmem_arbiter #(.MEM_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .req0       (req0_v[g]),
      .we0        (we0_v[g]),
      .addr0      (addr0_v[g]),
      .wdata0     (wdata0_v[g]),
      .req1       (req1_v[g]),
      .we1        (we1_v[g]),
      .addr1      (addr1_v[g]),
      .wdata1     (wdata1_v[g]),
      .gnt0       (gnt0_v[g]),
      .gnt1       (gnt1_v[g]),
      .rvalid0    (rvalid0_v[g]),
      .rvalid1    (rvalid1_v[g]),
      .rdata0     (rdata0_v[g]),
      .rdata1     (rdata1_v[g]),
      .core_stall (core_stall_v[g]),
      .mem_en     (mem_en_v[g]),
      .mem_we     (mem_we_v[g]),
      .mem_addr   (mem_addr_v[g]),
      .mem_wdata  (mem_wdata_v[g]),
      .mem_rdata  (mem_rdata_v[g])
    );

    // Memory model: read data appears exactly LAT cycles after mem_en, junk otherwise.
    always @(posedge clk) begin
      if (rst_v[g]) begin
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        mem[6] <= 32'h3E81_2503;
        mem[7] <= 32'h0BAD_CAFE;
        mem[8] <= 32'h1111_2222;
        mem[9] <= 32'h3333_4444;
      end else if (mem_en_v[g] && mem_we_v[g]) begin
        mem[mem_addr_v[g][5:2]] <= mem_wdata_v[g];
      end
      pipe[0] <= (mem_en_v[g] && !mem_we_v[g]) ? mem[mem_addr_v[g][5:2]] : 32'hBAAD_F00D;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata_v[g] = pipe[LAT-1];

    // Monitor: every access strobe and completion must match the next expectation.
    always @(negedge clk) begin
      if (!rst_v[g]) begin
        if (gnt0_v[g] || gnt1_v[g] || mem_en_v[g]) begin
          if (gnt_q[g].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL gnt_unexpected[%0d] @cycle %0d: got mem_en=%b gnt0=%b gnt1=%b, expected no access",
                     g, cyc, mem_en_v[g], gnt0_v[g], gnt1_v[g]);
          end else begin
            gexp_t e;
            e = gnt_q[g].pop_front();
            chk($sformatf("gnt_port[%0d]", g), {29'd0, gnt1_v[g], gnt0_v[g], mem_en_v[g]},
                {29'd0, e.port, ~e.port, 1'b1});
            chk($sformatf("gnt_cycle[%0d]", g), cyc, e.cyc);
            chk($sformatf("mem_addr[%0d]", g), mem_addr_v[g], e.addr);
            chk($sformatf("mem_we[%0d]", g), mem_we_v[g], e.we);
            chk($sformatf("mem_wdata[%0d]", g), mem_wdata_v[g], e.wdata);
          end
        end
        if (rvalid0_v[g] || rvalid1_v[g]) begin
          if (rsp_q[g].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL rvalid_unexpected[%0d] @cycle %0d: got rvalid0=%b rvalid1=%b, expected none",
                     g, cyc, rvalid0_v[g], rvalid1_v[g]);
          end else begin
            rexp_t e;
            e = rsp_q[g].pop_front();
            chk($sformatf("rvalid_port[%0d]", g), {30'd0, rvalid1_v[g], rvalid0_v[g]},
                {30'd0, e.port, ~e.port});
            chk($sformatf("rvalid_cycle[%0d]", g), cyc, e.cyc);
            chk($sformatf("rdata_owner[%0d]", g), e.port ? rdata1_v[g] : rdata0_v[g], e.data);
            chk($sformatf("rdata_other[%0d]", g), e.port ? rdata0_v[g] : rdata1_v[g], 32'h0);
          end
        end
      end
    end
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic set_port(input int d, input bit port, input bit r, input bit we,
                          input logic [31:0] a, input logic [31:0] wd);
    if (port) begin
      req1_v[d] = r; we1_v[d] = we; addr1_v[d] = a; wdata1_v[d] = wd;
    end else begin
      req0_v[d] = r; we0_v[d] = we; addr0_v[d] = a; wdata0_v[d] = wd;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input int d, input bit port, input int c, input logic [31:0] a,
                          input bit we, input logic [31:0] wd);
    gexp_t e;
    e.port = port; e.cyc = c; e.addr = a; e.we = we; e.wdata = wd;
    gnt_q[d].push_back(e);
  endtask

  task automatic push_rsp(input int d, input bit port, input int c, input logic [31:0] data);
    rexp_t e;
    e.port = port; e.cyc = c; e.data = data;
    rsp_q[d].push_back(e);
  endtask

  task automatic chk_quiet(input int d, input string name);
    chk({name, "_ctl"}, {26'd0, gnt0_v[d], gnt1_v[d], rvalid0_v[d], rvalid1_v[d],
                         mem_en_v[d], mem_we_v[d]}, 32'h0);
    chk({name, "_data"}, rdata0_v[d] | rdata1_v[d] | mem_addr_v[d] | mem_wdata_v[d], 32'h0);
  endtask

  // One access from an idle arbiter; the requester holds req until its response.
  task automatic single(input int d, input bit port, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp);
    int L = lat(d);
    int c = cyc;
    set_port(d, port, 1'b1, we, a, wd);
    push_gnt(d, port, c + 1, a & 32'hFFFF_FFFC, we, wd);
    push_rsp(d, port, c + L + 2, we ? 32'h0 : exp);
    for (int k = 0; k <= L + 2; k++) begin
      @(negedge clk);
      chk("core_stall", core_stall_v[d], {31'd0, (port == 1'b0) && (k != L + 2)});
      next_cycle();
    end
    set_port(d, port, 1'b0, 1'b0, 32'h0, 32'h0);
    last_served[d] = port;
  endtask

  // Both ports request on the same edge; loser is served after a full access.
  task automatic tie(input int d);
    int L = lat(d);
    int c = cyc;
    bit w;
`ifdef DMEM_ARB_RR_EN
    w = ~last_served[d];
`else
    w = 1'b1;
`endif
    set_port(d, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    set_port(d, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    push_gnt(d, w, c + 1, w ? 32'h24 : 32'h20, 1'b0, 32'h0);
    push_rsp(d, w, c + L + 2, w ? 32'h3333_4444 : 32'h1111_2222);
    push_gnt(d, !w, c + L + 4, w ? 32'h20 : 32'h24, 1'b0, 32'h0);
    push_rsp(d, !w, c + 2 * L + 5, w ? 32'h1111_2222 : 32'h3333_4444);
    repeat (L + 3) next_cycle();
    set_port(d, w, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (L + 3) next_cycle();
    set_port(d, !w, 1'b0, 1'b0, 32'h0, 32'h0);
    last_served[d] = !w;
  endtask

  // Reset lands in the WAIT state: access is abandoned with no completion.
  task automatic reset_in_wait(input int d);
    int c = cyc;
    set_port(d, 1'b0, 1'b1, 1'b0, 32'h18, 32'h0);
    push_gnt(d, 1'b0, c + 1, 32'h18, 1'b0, 32'h0);
    next_cycle();
    set_port(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    rst_v[d] = 1'b1;
    next_cycle();
    rst_v[d] = 1'b0;
    @(negedge clk);
    chk_quiet(d, "after_rst");
    next_cycle();
    last_served[d] = 1'b1;
  endtask

  // req0 held continuously: one access every MEM_LAT+3 cycles.
  task automatic stream(input int d, input int n);
    int L = lat(d);
    int P = L + 3;
    int c = cyc;
    set_port(d, 1'b0, 1'b1, 1'b0, 32'h18, 32'h0);
    for (int j = 0; j < n; j++) begin
      push_gnt(d, 1'b0, c + 1 + j * P, 32'h18, 1'b0, 32'h0);
      push_rsp(d, 1'b0, c + L + 2 + j * P, 32'h3E81_2503);
    end
    for (int k = 0; k < n * P; k++) begin
      @(negedge clk);
      chk("stream_stall", core_stall_v[d], {31'd0, (k % P) != (L + 2)});
      next_cycle();
    end
    set_port(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    last_served[d] = 1'b0;
  endtask

  initial begin
    rst_v = 2'b11;
    req0_v = '0; req1_v = '0; we0_v = '0; we1_v = '0;
    addr0_v = '0; addr1_v = '0; wdata0_v = '0; wdata1_v = '0;
    last_served[0] = 1'b1;
    last_served[1] = 1'b1;

    repeat (2) next_cycle();
    req0_v[0] = 1'b1;
    @(negedge clk);
    chk_quiet(0, "reset0");
    chk_quiet(1, "reset1");
    chk("stall_in_rst_hi", core_stall_v[0], 32'h1);
    next_cycle();
    req0_v[0] = 1'b0;
    rst_v = 2'b00;
    @(negedge clk);
    chk("stall_in_idle_lo", core_stall_v[0], 32'h0);
    next_cycle();

    tie(0);
    tie(0);
    single(0, 1'b0, 1'b0, 32'h18, 32'h0, 32'h3E81_2503);
    single(0, 1'b1, 1'b1, 32'h7, 32'hDEAD_BEEF, 32'h0);
    single(0, 1'b0, 1'b0, 32'h4, 32'h0, 32'hDEAD_BEEF);
    reset_in_wait(0);
    single(0, 1'b0, 1'b0, 32'h18, 32'h0, 32'h3E81_2503);
    stream(0, 3);

    single(1, 1'b0, 1'b0, 32'h18, 32'h0, 32'h3E81_2503);
    single(1, 1'b1, 1'b0, 32'h1C, 32'h0, 32'h0BAD_CAFE);

    repeat (4) next_cycle();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("gnt_left[%0d]", d), gnt_q[d].size(), 32'h0);
      chk($sformatf("rsp_left[%0d]", d), rsp_q[d].size(), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer sharing the single data memory between the core's load/store port (port 0) and the program loader/debug port (port 1). Accepts one request at a time via a req/gnt/rvalid handshake, drives a fixed-latency synchronous memory, returns read data to the winning port, and produces the core stall. Sits between the core datapath (ALU result as address, regfile data2 as write data, writeback mux) and the memory macro.

## Interface
- MEM_LAT, 1: cycles from mem_en to valid mem_rdata; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0 / req1  in  1  access request, port 0 (core) / port 1 (loader).
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  one-cycle pulse: request fields latched.
- rvalid0 / rvalid1  out  1  one-cycle completion pulse (reads and writes).
- rdata0 / rdata1  out  32  read data, valid only with matching rvalid.
- core_stall  out  1  hold core PC/regfile writes.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  32  word address, addr with [1:0] forced to 00.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.

## Operation
- States: IDLE, ACCESS, WAIT, RESP. Reset state IDLE.
- IDLE: sample req0/req1 at rising edge; if any, pick winner, latch owner/we/addr/wdata, go ACCESS. Else stay.
- Fixed priority (default): port 1 wins when both request.
- ACCESS (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latch; gnt of owner=1; load counter with MEM_LAT; go WAIT.
- WAIT: decrement counter each cycle; on the cycle counter reaches 1, capture mem_rdata into rdata register (writes capture 0); go RESP.
- RESP (1 cycle): rvalid of owner=1, rdata of owner=captured value, other port rdata=0; go IDLE.
- Requester holds req and fields stable until gnt; may drop req from gnt cycle on. req still high on return to IDLE is a new request.
- core_stall = req0 & ~rvalid0 (combinational); asserted whenever core request pending and not completing this cycle.
- Non-owner outputs gnt/rvalid/rdata always 0.
- rst in any state: next cycle IDLE, counter 0, latches cleared; in-flight access abandoned, no rvalid emitted, late mem_rdata ignored.

## Timing
- Reset values: gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; core_stall follows req0.
- req sampled at edge E → ACCESS cycle E+1 (gnt, mem_en) → WAIT MEM_LAT cycles → RESP cycle E+MEM_LAT+2.
- Request-to-rvalid latency: MEM_LAT+2 cycles; back-to-back throughput one access per MEM_LAT+3 cycles.
- Loser of simultaneous request waits a full access; served at next IDLE if still requesting.
- All outputs except core_stall registered.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin; 1-bit last-served pointer, reset to 1 (port 0 wins first tie), updated to owner in ACCESS; on simultaneous requests, port not last served wins.
- Undefined: fixed priority, port 1 always wins ties; no pointer state.

## Test plan
- MEM_LAT=1, port 0 read addr 0x18, memory returns 0x3E812503 → gnt0 cycle 1, mem_addr=0x18, rvalid0 cycle 3, rdata0=0x3E812503, core_stall high cycles 0-2, low cycle 3.
- Port 1 write addr 0x7 data 0xDEADBEEF → mem_addr=0x4, mem_we=1, mem_wdata=0xDEADBEEF one cycle; rvalid1 pulse, rdata1=0.
- req0 and req1 same edge, fixed priority → port 1 served first, port 0 gnt at ACCESS following RESP; with DMEM_ARB_RR_EN port 0 first, then port 1, then port 0 on repeated ties.
- MEM_LAT=4, port 0 read → rvalid0 exactly 6 cycles after request edge; mem_en asserted exactly once.
- rst asserted during WAIT → IDLE next cycle, no rvalid, all outputs zero; new req0 afterward completes normally.
- Continuous req0 held high → one access per MEM_LAT+3 cycles, core_stall low only in rvalid0 cycles.
